// File: rtl/agen_lsu_queue.sv
// In-order decoupling FIFO between the M-lane AGEN and the LSU, with almost-full throttle and flush.
// Define AGEN_LSU_BYPASS_EN to pass a request straight through to the LSU when the queue is empty.
module agen_lsu_queue #(
    parameter int PKT_W = 100,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             memValid_i,
    input  logic [PKT_W-1:0] memPkt_i,
    output logic             memReady_o,
    output logic             almostFull_o,
    output logic             lsuValid_o,
    output logic [PKT_W-1:0] lsuPkt_o,
    input  logic             lsuReady_i,
    output logic [CNT_W-1:0] occupancy_o,
    output logic             overflowErr_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - 1);

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             full, nonempty, bypass, push, pop;

    assign full     = (cnt_q == FULL_CNT);
    assign nonempty = (cnt_q != '0);

`ifdef AGEN_LSU_BYPASS_EN
    assign bypass = ~nonempty & memValid_i & lsuReady_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed request is consumed by the LSU directly and never enqueued.
    assign push = memValid_i & ~full & ~flush_i & ~bypass;
    assign pop  = nonempty & lsuReady_i & ~flush_i;

    assign memReady_o    = ~full;
    assign almostFull_o  = (cnt_q >= AFULL_CNT);
    assign lsuValid_o    = nonempty | bypass;
    assign lsuPkt_o      = bypass ? memPkt_i : (nonempty ? mem_q[head_q] : '0);
    assign occupancy_o   = cnt_q;
    assign overflowErr_o = ovf_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q | (memValid_i & full & ~flush_i);
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (pop) head_d = head_q + 1'b1;
            if (push) tail_d = tail_q + 1'b1;
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // Payload storage is never reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= memPkt_i;
    end

endmodule

// File: tb/tb_agen_lsu_queue.sv
// Bench for agen_lsu_queue: fixed vector table, corner sequences and random traffic vs a queue model.
module tb_agen_lsu_queue;
    localparam int PKT_W = 100;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset, flush_i, memValid_i, lsuReady_i;
    logic [PKT_W-1:0] memPkt_i, lsuPkt_o;
    logic             memReady_o, almostFull_o, lsuValid_o, overflowErr_o;
    logic [CNT_W-1:0] occupancy_o;

    int checks = 0;
    int errors = 0;

    logic [PKT_W-1:0] mq[$];
    logic             movf = 1'b0;

    typedef struct {
        logic             v;
        logic [PKT_W-1:0] pkt;
        logic             rdy;
        logic             mr;
        logic             af;
        logic             lv;
        logic [PKT_W-1:0] lp;
        logic [CNT_W-1:0] occ;
        logic             ovf;
    } vec_t;

    vec_t tab[11];
    vec_t nv;

    agen_lsu_queue #(.PKT_W(PKT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .memValid_i(memValid_i), .memPkt_i(memPkt_i), .memReady_o(memReady_o),
        .almostFull_o(almostFull_o), .lsuValid_o(lsuValid_o), .lsuPkt_o(lsuPkt_o),
        .lsuReady_i(lsuReady_i), .occupancy_o(occupancy_o), .overflowErr_o(overflowErr_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit v, int pkt, bit rdy, bit mr, bit af, bit lv, int lp, int occ, bit ovf);
        vec_t t;
        t.v = v; t.pkt = PKT_W'(pkt); t.rdy = rdy;
        t.mr = mr; t.af = af; t.lv = lv; t.lp = PKT_W'(lp); t.occ = CNT_W'(occ); t.ovf = ovf;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare against the model (and optionally a table record), then advance.
    task automatic cyc(input logic rst_n, input logic fl, input logic v, input logic [PKT_W-1:0] pkt,
                       input logic rdy, input bit use_tab, input vec_t tv);
        int               cnt;
        logic             byp;
        logic [PKT_W-1:0] ep;
        reset = rst_n; flush_i = fl; memValid_i = v; memPkt_i = pkt; lsuReady_i = rdy;
        #4;
        cnt = mq.size();
`ifdef AGEN_LSU_BYPASS_EN
        byp = (cnt == 0) && v && rdy && !fl;
`else
        byp = 1'b0;
`endif
        ep = byp ? pkt : ((cnt != 0) ? mq[0] : '0);
        chk("memReady",   PKT_W'(memReady_o),    PKT_W'(cnt < DEPTH));
        chk("almostFull", PKT_W'(almostFull_o),  PKT_W'(cnt >= DEPTH - 1));
        chk("lsuValid",   PKT_W'(lsuValid_o),    PKT_W'((cnt != 0) || byp));
        chk("lsuPkt",     lsuPkt_o,              ep);
        chk("occupancy",  PKT_W'(occupancy_o),   PKT_W'(cnt));
        chk("overflowErr", PKT_W'(overflowErr_o), PKT_W'(movf));
        if (use_tab) begin
            chk("tab_memReady",   PKT_W'(memReady_o),    PKT_W'(tv.mr));
            chk("tab_almostFull", PKT_W'(almostFull_o),  PKT_W'(tv.af));
            chk("tab_lsuValid",   PKT_W'(lsuValid_o),    PKT_W'(tv.lv));
            chk("tab_lsuPkt",     lsuPkt_o,              tv.lp);
            chk("tab_occupancy",  PKT_W'(occupancy_o),   PKT_W'(tv.occ));
            chk("tab_overflow",   PKT_W'(overflowErr_o), PKT_W'(tv.ovf));
        end
        if (!rst_n) begin
            mq.delete();
            movf = 1'b0;
        end else if (fl) begin
            mq.delete();
        end else if (!byp) begin
            if (cnt != 0 && rdy) void'(mq.pop_front());
            if (v) begin
                if (cnt < DEPTH) mq.push_back(pkt);
                else movf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rst_n, input logic fl, input logic v, input logic [PKT_W-1:0] pkt,
                        input logic rdy);
        cyc(rst_n, fl, v, pkt, rdy, 1'b0, nv);
    endtask

    initial begin
        logic [127:0] r;
        nv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        //              v  pkt    rdy mr af lv lp     occ ovf
        tab[0]  = mk(1, 'hA1, 0, 1, 0, 0, 0,    0, 0);
        tab[1]  = mk(1, 'hB2, 0, 1, 0, 1, 'hA1, 1, 0);
        tab[2]  = mk(1, 'hC3, 0, 1, 0, 1, 'hA1, 2, 0);
        tab[3]  = mk(1, 'hD4, 0, 1, 1, 1, 'hA1, 3, 0);
        tab[4]  = mk(0, 0,    0, 0, 1, 1, 'hA1, 4, 0);
        tab[5]  = mk(1, 'hE5, 1, 0, 1, 1, 'hA1, 4, 0);
        tab[6]  = mk(0, 0,    0, 1, 1, 1, 'hB2, 3, 1);
        tab[7]  = mk(0, 0,    1, 1, 1, 1, 'hB2, 3, 1);
        tab[8]  = mk(0, 0,    1, 1, 0, 1, 'hC3, 2, 1);
        tab[9]  = mk(0, 0,    1, 1, 0, 1, 'hD4, 1, 1);
        tab[10] = mk(0, 0,    0, 1, 0, 0, 0,    0, 1);

        reset = 1'b0; flush_i = 1'b0; memValid_i = 1'b1; memPkt_i = '0; lsuReady_i = 1'b0;
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, 1'b1, PKT_W'('h77), 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);

        for (int i = 0; i < 11; i++)
            cyc(1'b1, 1'b0, tab[i].v, tab[i].pkt, tab[i].rdy, 1'b1, tab[i]);

        // Two entries resident, then one push and one pop every cycle across pointer wrap.
        step(1'b1, 1'b0, 1'b1, PKT_W'('h100), 1'b0);
        step(1'b1, 1'b0, 1'b1, PKT_W'('h101), 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 1'b1, PKT_W'('h200 + k), 1'b1);
            chk("steady_occ", PKT_W'(occupancy_o), PKT_W'(2));
        end

        // Flush at count 3 with a concurrent push.
        step(1'b1, 1'b0, 1'b1, PKT_W'('h300), 1'b0);
        step(1'b1, 1'b1, 1'b1, PKT_W'('h301), 1'b0);
        chk("flush_occ", PKT_W'(occupancy_o), PKT_W'(0));
        chk("flush_lsuValid", PKT_W'(lsuValid_o), PKT_W'(0));
        chk("flush_ovf_kept", PKT_W'(overflowErr_o), PKT_W'(1));

        // Empty queue, request with LSU ready.
`ifdef AGEN_LSU_BYPASS_EN
        cyc(1'b1, 1'b0, 1'b1, PKT_W'('h5A), 1'b1, 1'b1, mk(1, 'h5A, 1, 1, 0, 1, 'h5A, 0, 1));
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, mk(0, 0, 0, 1, 0, 0, 0, 0, 1));
`else
        cyc(1'b1, 1'b0, 1'b1, PKT_W'('h5A), 1'b1, 1'b1, mk(1, 'h5A, 1, 1, 0, 0, 0, 0, 1));
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, mk(0, 0, 0, 1, 0, 1, 'h5A, 1, 1));
`endif
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(63) != 0), ($urandom_range(15) == 0), ($urandom_range(3) != 0),
                 r[PKT_W-1:0], ($urandom_range(2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
